hw1_uart_tx: RTL and testbench

//  Transmit-only UART serializer. Sends one byte from indata on uart_txd as an async serial frame:
//  1 start bit (0), 8 data bits LSB first, optional parity bit, then stop bit(s) (1).
//  A frame starts on a rising edge of the write strobe. Sits between a CPU/register strobe and the board TX pin.

---
 rtl/hw1_uart_tx.sv | 134 +++++++++++++
 tb/tb_hw1_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hw1_uart_tx.sv
// Transmit-only UART: one start bit, eight data bits LSB first, optional parity, one or two stop bits.
// The line and busy flag are registered from the next-state decode so both change on the same edge as the state.
module hw1_uart_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk_50M,
   input  logic       reset_n,
   input  logic       write,
   input  logic [7:0] indata,
   output logic       uart_txd,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic            r_syncQ1;
   logic            r_syncQ2;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shreg;
   logic [7:0]      r_data;
   logic            r_txd;
   logic            r_busy;
   logic            w_rise;
   logic            w_bitDone;
   logic            w_parity;
   logic            w_txdNext;
   logic            w_busyNext;

   // write is asynchronous to the clock, so it is synchronised before the rising-edge detect
   always_ff @(posedge clk_50M) begin
      if (reset_n) begin
         r_syncQ1 <= 1'b0;
         r_syncQ2 <= 1'b0;
      end else begin
         r_syncQ1 <= write;
         r_syncQ2 <= r_syncQ1;
      end
   end

   assign w_rise    = r_syncQ1 & ~r_syncQ2;
   assign w_bitDone = (r_cnt == LAST_CNT);
   assign w_parity  = (PARITY == 1) ? ~^r_data : ^r_data;

   always_ff @(posedge clk_50M) begin
      if (reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:   if (w_rise) w_stateNext = S_START;
         S_START:  if (w_bitDone) w_stateNext = S_DATA;
         S_DATA:   if (w_bitDone && r_idx == 3'd7) w_stateNext = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_bitDone) w_stateNext = S_STOP;
         S_STOP:   if (w_bitDone && r_idx == LAST_STOP) w_stateNext = S_IDLE;
         default:  w_stateNext = S_IDLE;
      endcase
   end

   // The bit index restarts on every state change, so it doubles as the stop-bit counter
   always_ff @(posedge clk_50M) begin
      if (reset_n) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shreg <= '0;
         r_data  <= '0;
      end else if (r_state == S_IDLE) begin
         r_cnt <= '0;
         r_idx <= '0;
         if (w_rise) begin
            r_shreg <= indata;
            r_data  <= indata;
         end
      end else begin
         r_cnt <= w_bitDone ? '0 : r_cnt + 1'b1;
         if (w_stateNext != r_state) begin
            r_idx <= '0;
         end else if (w_bitDone) begin
            r_idx <= r_idx + 3'd1;
         end
         if (r_state == S_DATA && w_bitDone) begin
            r_shreg <= {1'b0, r_shreg[7:1]};
         end
      end
   end

   always_comb begin
      w_txdNext  = 1'b1;
      w_busyNext = 1'b1;
      case (w_stateNext)
         S_IDLE:   w_busyNext = 1'b0;
         S_START:  w_txdNext  = 1'b0;
         S_DATA:   w_txdNext  = (r_state == S_DATA && w_bitDone) ? r_shreg[1] : r_shreg[0];
         S_PARITY: w_txdNext  = w_parity;
         S_STOP:   w_txdNext  = 1'b1;
         default:  w_txdNext  = 1'b1;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (reset_n) begin
         r_txd  <= 1'b1;
         r_busy <= 1'b0;
      end else begin
         r_txd  <= w_txdNext;
         r_busy <= w_busyNext;
      end
   end

   assign uart_txd = r_txd;
   assign tx_busy  = r_busy;

endmodule

// File: tb/tb_hw1_uart_tx.sv
// Bench for hw1_uart_tx: three instances (no parity/1 stop, odd/2 stop, even/1 stop) at 10 clocks per bit,
// each watched by a reference receiver that pops the expected byte from a scoreboard queue.
module tb_hw1_uart_tx;

   localparam int CPB = 10;
   localparam int NI  = 3;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       write  = 1'b0;
   logic [7:0] indata = 8'h00;
   logic [2:0] txd;
   logic [2:0] busy;

   int checks   = 0;
   int failures = 0;
   int nPushed  = 0;

   logic [7:0] expQ0[$];
   logic [7:0] expQ1[$];
   logic [7:0] expQ2[$];

   bit         rxActive [NI];
   int         rxCnt    [NI];
   logic [7:0] rxByte   [NI];
   logic       rxPar    [NI];
   int         busyLen  [NI];
   bit         prevBusy [NI];
   int         busyFalls[NI];

   typedef struct {
      logic [7:0] data;
      int         holdClks;
      int         offsetNs;
      bit         expectFrame;
      int         gapClks;
   } vec_t;

   vec_t vecs[8];

   hw1_uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk_50M(clk), .reset_n(reset), .write(write), .indata(indata),
      .uart_txd(txd[0]), .tx_busy(busy[0]));
   hw1_uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(1), .STOP_BITS(2)) u1 (
      .clk_50M(clk), .reset_n(reset), .write(write), .indata(indata),
      .uart_txd(txd[1]), .tx_busy(busy[1]));
   hw1_uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk_50M(clk), .reset_n(reset), .write(write), .indata(indata),
      .uart_txd(txd[2]), .tx_busy(busy[2]));

   always #10 clk = ~clk;

   function automatic int parOf(input int k);
      return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
   endfunction

   function automatic int stopOf(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic int nBits(input int k);
      return 9 + ((parOf(k) != 0) ? 1 : 0) + stopOf(k);
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic [7:0] d);
      expQ0.push_back(d);
      expQ1.push_back(d);
      expQ2.push_back(d);
      nPushed++;
   endtask

   function automatic int qSize(input int k);
      return (k == 0) ? expQ0.size() : ((k == 1) ? expQ1.size() : expQ2.size());
   endfunction

   task automatic popExp(input int k, output logic [7:0] d);
      if (k == 0) d = expQ0.pop_front();
      else if (k == 1) d = expQ1.pop_front();
      else d = expQ2.pop_front();
   endtask

   task automatic finishFrame(input int k);
      logic [7:0] e;
      if (qSize(k) == 0) begin
         checkOutput($sformatf("unexpected frame u%0d byte %0h", k, rxByte[k]), 1, 0);
      end else begin
         popExp(k, e);
         checkOutput($sformatf("rx byte u%0d", k), int'(rxByte[k]), int'(e));
         if (parOf(k) == 1) checkOutput($sformatf("odd parity u%0d", k), int'(rxPar[k]), int'(~^e));
         if (parOf(k) == 2) checkOutput($sformatf("even parity u%0d", k), int'(rxPar[k]), int'(^e));
      end
   endtask

   // Reference receivers and busy-width monitors, sampling mid-cycle so the registered line is stable
   always @(negedge clk) begin
      int b;
      for (int k = 0; k < NI; k++) begin
         if (reset) begin
            rxActive[k] = 1'b0;
            busyLen[k]  = 0;
            prevBusy[k] = 1'b0;
         end else begin
            if (busy[k] === 1'b1) begin
               busyLen[k]++;
            end else if (prevBusy[k]) begin
               checkOutput($sformatf("frame length u%0d", k), busyLen[k], nBits(k) * CPB);
               busyFalls[k]++;
               busyLen[k] = 0;
            end
            prevBusy[k] = (busy[k] === 1'b1);
            if (!rxActive[k] && txd[k] === 1'b0) begin
               rxActive[k] = 1'b1;
               rxCnt[k]    = 0;
            end
            if (rxActive[k]) begin
               if (rxCnt[k] % CPB == CPB / 2) begin
                  b = rxCnt[k] / CPB;
                  if (b == 0) begin
                     checkOutput($sformatf("start bit u%0d", k), int'(txd[k]), 0);
                  end else if (b <= 8) begin
                     rxByte[k][b-1] = txd[k];
                  end else if (parOf(k) != 0 && b == 9) begin
                     rxPar[k] = txd[k];
                  end else begin
                     checkOutput($sformatf("stop bit u%0d", k), int'(txd[k]), 1);
                  end
                  if (b == nBits(k) - 1) begin
                     finishFrame(k);
                     rxActive[k] = 1'b0;
                  end
               end
               rxCnt[k]++;
            end
         end
      end
   end

   // Drives one write pulse off the clock edge and, when a frame is expected, measures start latency
   task automatic applyStimulus(input logic [7:0] d, input int hold, input int offsetNs, input bit expectFrame);
      int lat;
      @(posedge clk);
      #(offsetNs);
      indata = d;
      write  = 1'b1;
      lat    = 0;
      if (expectFrame) begin
         pushExp(d);
         while (txd[0] !== 1'b0 && lat < 8) begin
            @(negedge clk);
            lat++;
         end
         checkOutput($sformatf("start latency %0d clks <= 4", lat), int'(lat <= 4), 1);
      end
      repeat (hold - lat) @(negedge clk);
      write  = 1'b0;
      indata = ~d;
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, " txd"}, int'(txd), 7);
      checkOutput({name, " busy"}, int'(busy), 0);
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{8'h21, 25,  3, 1'b1, 150};
      vecs[1] = '{8'h43, 25,  7, 1'b1, 150};
      vecs[2] = '{8'h65, 25, 13, 1'b1, 150};
      vecs[3] = '{8'h00,  5,  4, 1'b1, 150};
      vecs[4] = '{8'hFF,  5,  9, 1'b1, 150};
      vecs[5] = '{8'h80,  3,  2, 1'b1, 150};
      vecs[6] = '{8'h01,  4, 17, 1'b1, 150};
      vecs[7] = '{8'h96, 360, 5, 1'b1, 150};
      for (int k = 0; k < NI; k++) busyFalls[k] = 0;

      repeat (5) @(negedge clk);
      checkIdle("reset held");
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checkIdle("after reset release");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].data, vecs[i].holdClks, vecs[i].offsetNs, vecs[i].expectFrame);
         repeat (vecs[i].gapClks) @(negedge clk);
         checkIdle($sformatf("idle after vec %0d", i));
      end

      applyStimulus(8'hA5, 10, 3, 1'b1);
      repeat (40) @(negedge clk);
      applyStimulus(8'hFF, 10, 6, 1'b0);
      repeat (150) @(negedge clk);
      checkIdle("idle after ignored write");

      @(posedge clk);
      #3;
      indata = 8'h3C;
      write  = 1'b1;
      pushExp(8'h3C);
      n = 0;
      while (txd[0] !== 1'b0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abort frame started", int'(n < 8), 1);
      write = 1'b0;
      repeat (44) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkIdle("abort in data bit 3");
      reset = 1'b0;
      expQ0.delete();
      expQ1.delete();
      expQ2.delete();
      nPushed--;
      repeat (20) @(negedge clk);
      applyStimulus(8'h55, 5, 7, 1'b1);
      repeat (150) @(negedge clk);
      checkIdle("idle after 55");

      for (int k = 0; k < NI; k++) begin
         checkOutput($sformatf("pending frames u%0d", k), qSize(k), 0);
         checkOutput($sformatf("busy falls u%0d", k), busyFalls[k], nPushed);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
